fifo_reset_sequencer: RTL

Sequences reset release and soft flush for a FIFO instance. It holds the FIFO core in reset for a programmed number of cycles after global reset, lets it settle, then enables the write side and, one cycle later, the read side. In run mode it accepts a level/acknowledge flush request that quiesces both ports, re-resets the FIFO and re-runs the release sequence. It sits between the system reset network and the FIFO wrapper, in the FIFO clock domain.

---
 rtl/fifo_reset_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_reset_sequencer.sv
// FIFO reset-release / soft-flush sequencer: HOLD -> SETTLE -> RUN (-> QUIESCE when FIFO_RSTSEQ_FLUSH_EN).
// All outputs registered; flush_req is a level held by the requester until the one-cycle flush_ack.
module fifo_reset_sequencer #(
  parameter int HOLD_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int QUIESCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_req,
  output logic fifo_rst_n,
  output logic wr_allow,
  output logic rd_allow,
  output logic ready,
  output logic flush_ack
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 256) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..256");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 256) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..256");
  end
  if (QUIESCE_CYCLES < 1 || QUIESCE_CYCLES > 256) begin : g_bad_quiesce
    $error("QUIESCE_CYCLES must be in 1..256");
  end

  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] QUIESCE_LAST = 8'(QUIESCE_CYCLES - 1);

`ifdef FIFO_RSTSEQ_FLUSH_EN
  typedef enum logic [1:0] {HOLD, SETTLE, RUN, QUIESCE} state_t;
  logic flush_pending;
`else
  typedef enum logic [1:0] {HOLD, SETTLE, RUN} state_t;
  logic unused_flush_req;
  assign unused_flush_req = flush_req;
  assign flush_ack        = 1'b0;
`endif

  state_t     state;
  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HOLD;
      count         <= 8'd0;
      fifo_rst_n    <= 1'b0;
      wr_allow      <= 1'b0;
      rd_allow      <= 1'b0;
      ready         <= 1'b0;
`ifdef FIFO_RSTSEQ_FLUSH_EN
      flush_pending <= 1'b0;
      flush_ack     <= 1'b0;
`endif
    end else begin
`ifdef FIFO_RSTSEQ_FLUSH_EN
      flush_ack <= 1'b0;
`endif
      case (state)
        HOLD: begin
          if (count == HOLD_LAST) begin
            state      <= SETTLE;
            count      <= 8'd0;
            fifo_rst_n <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        SETTLE: begin
          if (count == SETTLE_LAST) begin
            state         <= RUN;
            count         <= 8'd0;
            wr_allow      <= 1'b1;
            ready         <= 1'b1;
`ifdef FIFO_RSTSEQ_FLUSH_EN
            flush_ack     <= flush_pending;
            flush_pending <= 1'b0;
`endif
          end else begin
            count <= count + 8'd1;
          end
        end
        RUN: begin
`ifdef FIFO_RSTSEQ_FLUSH_EN
          // The ack cycle masks flush_req so a held request cannot re-trigger until it has seen the ack.
          if (flush_req && !flush_ack) begin
            state    <= QUIESCE;
            count    <= 8'd0;
            wr_allow <= 1'b0;
            rd_allow <= 1'b0;
            ready    <= 1'b0;
          end else begin
            rd_allow <= wr_allow;
          end
`else
          rd_allow <= wr_allow;
`endif
        end
`ifdef FIFO_RSTSEQ_FLUSH_EN
        QUIESCE: begin
          if (count == QUIESCE_LAST) begin
            state         <= HOLD;
            count         <= 8'd0;
            fifo_rst_n    <= 1'b0;
            flush_pending <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
`endif
        default: begin
          state      <= HOLD;
          count      <= 8'd0;
          fifo_rst_n <= 1'b0;
          wr_allow   <= 1'b0;
          rd_allow   <= 1'b0;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule
